// File: rtl/vdp_pixel_mux.sv
// vdp_pixel_mux: two-stage background/sprite/backdrop priority mux with CPU-written 32x12 colour RAM.
module vdp_pixel_mux (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] bg_color,
  input  logic       bg_priority,
  input  logic [3:0] spr_color,
  input  logic       active,
  input  logic [3:0] backdrop,
  input  logic       cram_we,
  input  logic [5:0] cram_a,
  input  logic [7:0] cram_d,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       pixel_valid
);
  logic [11:0] cram [32];
  logic [7:0] latch;
  logic [4:0] idx, idx_d;
  logic act, live, spr_wins, unused;
  assign unused = bg_color[0];
  always_comb begin
    spr_wins = spr_color != 4'd0 && !(bg_priority && bg_color[4:1] != 4'd0);
    idx_d = !active ? {1'b1, backdrop} : spr_wins ? {1'b1, spr_color} : bg_color[5:1];
  end
  // CRAM is never cleared; writes coinciding with reset are dropped
  always_ff @(posedge clk)
    if (!rst && cram_we && cram_a[0])
      cram[cram_a[5:1]] <= {latch[3:0], latch[7:4], cram_d[3:0]};
  // live masks the first post-reset cycle, whose stage-1 index is still the reset value
  always_ff @(posedge clk)
    if (rst) begin
      latch <= '0;
      idx <= '0;
      act <= 1'b0;
      live <= 1'b0;
      {red, green, blue} <= '0;
      pixel_valid <= 1'b0;
    end else begin
      if (cram_we && !cram_a[0]) latch <= cram_d;
      idx <= idx_d;
      act <= active;
      live <= 1'b1;
      {red, green, blue} <= live ? cram[idx] : 12'h000;
      pixel_valid <= act;
    end
endmodule

// File: tb/tb_vdp_pixel_mux.sv
// tb_vdp_pixel_mux: spec-level model with per-cycle compare plus directed literal checks.
module tb_vdp_pixel_mux;
  logic clk = 0, rst = 1;
  logic [5:0] bg_color = 0;
  logic bg_priority = 0;
  logic [3:0] spr_color = 0;
  logic active = 0;
  logic [3:0] backdrop = 0;
  logic cram_we = 0;
  logic [5:0] cram_a = 0;
  logic [7:0] cram_d = 0;
  logic [3:0] red, green, blue;
  logic pixel_valid;
  int checks = 0, passed = 0;

  vdp_pixel_mux dut (
    .clk(clk), .rst(rst), .bg_color(bg_color), .bg_priority(bg_priority),
    .spr_color(spr_color), .active(active), .backdrop(backdrop),
    .cram_we(cram_we), .cram_a(cram_a), .cram_d(cram_d),
    .red(red), .green(green), .blue(blue), .pixel_valid(pixel_valid)
  );

  always #5 clk = ~clk;

  // model: colour table with written flags, pixel pipeline as plain variables
  int m_cram [32];
  bit m_known [32];
  int m_latch = 0, p_idx = 0;
  bit p_act = 0, p_live = 0;
  int e_rgb = 0;
  bit e_v = 0, e_known = 1;

  function automatic int pick(bit act, int bgc, bit bgp, int spr, int bd);
    int bg_idx = (bgc / 2) % 16;
    if (!act) return 16 + bd;
    if (spr != 0 && !(bgp && bg_idx != 0)) return 16 + spr;
    return bgc / 2;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      e_rgb = 0; e_v = 0; e_known = 1;
      p_idx = 0; p_act = 0; p_live = 0; m_latch = 0;
    end else begin
      e_v = p_act;
      e_known = !p_live || m_known[p_idx];
      e_rgb = p_live ? m_cram[p_idx] : 0;
      p_idx = pick(active, bg_color, bg_priority, spr_color, backdrop);
      p_act = active;
      p_live = 1;
      if (cram_we && cram_a[0]) begin
        m_cram[cram_a / 2] = (m_latch % 16) * 256 + (m_latch / 16) * 16 + cram_d % 16;
        m_known[cram_a / 2] = 1;
      end else if (cram_we) m_latch = cram_d;
    end
  end

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  always @(negedge clk) begin
    chk("model_valid", pixel_valid, e_v);
    if (e_known) chk("model_rgb", {red, green, blue}, e_rgb);
  end

  task automatic step(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(int a, int d);
    cram_we = 1; cram_a = 6'(a); cram_d = 8'(d);
    step();
    cram_we = 0;
  endtask

  task automatic pix(bit act, int bgc, bit bgp, int spr, int bd);
    active = act; bg_color = 6'(bgc); bg_priority = bgp; spr_color = 4'(spr); backdrop = 4'(bd);
  endtask

  task automatic lit(string name, int rgb, bit v);
    chk({name, "_rgb"}, {red, green, blue}, rgb);
    chk({name, "_valid"}, pixel_valid, v);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin m_cram[i] = 0; m_known[i] = 0; end
    step(3);
    lit("reset", 12'h000, 0);
    pix(1, 0, 0, 0, 0);
    rst = 0;
    step();
    lit("release_first", 12'h000, 0);
    step();
    chk("release_second_valid", pixel_valid, 1);
    wr(0, 8'h5A); wr(1, 8'hF3);
    pix(1, 8'h00, 0, 0, 0); step(2);
    lit("entry0", 12'hA53, 1);
    wr(34, 8'h21); wr(35, 8'h03); wr(4, 8'hFF); wr(5, 8'h0F);
    pix(1, 8'h04, 0, 1, 0); step(2);
    lit("spr_front", 12'h123, 1);
    pix(1, 8'h04, 1, 1, 0); step(2);
    lit("bg_priority", 12'hFFF, 1);
    pix(1, 8'h05, 1, 1, 0); step(2);
    lit("bg_bit0_ignored", 12'hFFF, 1);
    pix(1, 8'h00, 1, 1, 0); step(2);
    lit("bg_transparent", 12'h123, 1);
    wr(42, 8'h07); wr(43, 8'h09);
    pix(0, 8'h04, 1, 1, 5); step(2);
    lit("backdrop", 12'h709, 0);
    wr(0, 8'h11); wr(2, 8'h22); wr(3, 8'h0C);
    pix(1, 8'h02, 0, 0, 0); step(2);
    lit("latch_last", 12'h22C, 1);
    wr(0, 8'h34); wr(3, 8'h05);
    lit("same_cycle_old", 12'h22C, 1);
    step();
    lit("next_cycle_new", 12'h435, 1);
    rst = 1; cram_we = 1; cram_a = 3; cram_d = 8'h0F;
    step();
    lit("mid_reset", 12'h000, 0);
    rst = 0; cram_we = 0;
    step(2);
    lit("write_in_reset_dropped", 12'h435, 1);
    wr(5, 8'h07);
    pix(1, 8'h04, 0, 0, 0); step(2);
    lit("latch_cleared", 12'h007, 1);
    pix(1, 8'h00, 0, 1, 0); step(2);
    lit("cram_kept", 12'h123, 1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
